// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage directly upstream of decode.
// Holds the fetch PC and keeps at most one req/ack fetch outstanding. Fetched words
// are buffered in a DEPTH-entry queue that feeds the IF/ID register. Any fetch that
// is in flight when a redirect arrives is marked as dropped, and its data is discarded.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, an ack that arrives while
// the queue is empty and decode is not stalled loads IF/ID directly, one cycle earlier.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_D,
    output logic [31:0] Instruction_D,
    output logic [31:0] PC_D,
    output logic        valid_D
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    // Fetch control state; req_r doubles as the "one request outstanding" flag.
    logic [31:0]   fetch_pc_r;
    logic          req_r;
    logic [31:0]   addr_r;
    logic          drop_r;

    // Fetch queue.
    logic [31:0]   q_instr_r [DEPTH];
    logic [31:0]   q_pc_r    [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;

    // IF/ID register.
    logic [31:0]   instr_d_r;
    logic [31:0]   pc_d_r;
    logic          valid_d_r;

    // Next-state helpers.
    logic          ack_fire_s;
    logic          accept_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic          still_waiting_s;
    logic [CW-1:0] count_next_s;
    logic [31:0]   fetch_pc_next_s;
    logic          req_next_s;
    logic [31:0]   addr_next_s;
    logic          drop_next_s;
    logic          unused_redirect_lsb_s;

    // The low two bits of the redirect target are forced to zero, so they are never read.
    assign unused_redirect_lsb_s = ^redirect_pc[1:0];

    // Decide what happens to the in-flight fetch, the queue and the next request.
    always_comb begin
        ack_fire_s      = req_r & imem_ack;
        // Keep the ack data only if the fetch is not stale and no redirect is flushing it.
        accept_s        = ack_fire_s & ~drop_r & ~redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass_s        = accept_s & (count_r == {CW{1'b0}}) & ~stall_D;
`else
        bypass_s        = 1'b0;
`endif
        push_s          = accept_s & ~bypass_s;
        pop_s           = ~redirect_valid & ~stall_D & (count_r != {CW{1'b0}});
        still_waiting_s = req_r & ~imem_ack;
        // The dropped mark stays on the pending request until its own ack arrives.
        drop_next_s     = still_waiting_s & (drop_r | redirect_valid);

        count_next_s    = count_r;
        fetch_pc_next_s = fetch_pc_r;
        if (redirect_valid) begin
            count_next_s    = {CW{1'b0}};
            fetch_pc_next_s = {redirect_pc[31:2], 2'b00};
        end else begin
            count_next_s = count_r + CW'(push_s) - CW'(pop_s);
            if (accept_s) begin
                fetch_pc_next_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_next_s = fetch_pc_r;
            end
        end

        // A pending request keeps its address. Otherwise, issue a new request when a
        // queue slot is free to receive its data.
        req_next_s  = 1'b0;
        addr_next_s = addr_r;
        if (still_waiting_s) begin
            req_next_s  = 1'b1;
            addr_next_s = addr_r;
        end else begin
            req_next_s  = (count_next_s < CW'(DEPTH));
            addr_next_s = fetch_pc_next_s;
        end
    end

    // Fetch PC, request handshake and stale-fetch tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
            drop_r     <= 1'b0;
        end else begin
            fetch_pc_r <= fetch_pc_next_s;
            req_r      <= req_next_s;
            addr_r     <= addr_next_s;
            drop_r     <= drop_next_s;
        end
    end

    // Queue storage: write each accepted word at the tail, together with its address.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_instr_r[tail_r] <= imem_rdata;
            q_pc_r[tail_r]    <= addr_r;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + AW'(1'b1);
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1'b1);
            end
            count_r <= count_next_s;
        end
    end

    // IF/ID register: redirect flush, then stall hold, then queue pop or bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_d_r <= 32'h0000_0000;
            pc_d_r    <= 32'h0000_0000;
            valid_d_r <= 1'b0;
        end else if (redirect_valid) begin
            instr_d_r <= 32'h0000_0000;
            valid_d_r <= 1'b0;
        end else if (stall_D) begin
            instr_d_r <= instr_d_r;
            pc_d_r    <= pc_d_r;
            valid_d_r <= valid_d_r;
        end else if (count_r != {CW{1'b0}}) begin
            instr_d_r <= q_instr_r[head_r];
            pc_d_r    <= q_pc_r[head_r];
            valid_d_r <= 1'b1;
        end else if (bypass_s) begin
            instr_d_r <= imem_rdata;
            pc_d_r    <= addr_r;
            valid_d_r <= 1'b1;
        end else begin
            instr_d_r <= 32'h0000_0000;
            valid_d_r <= 1'b0;
        end
    end

    assign imem_req      = req_r;
    assign imem_addr     = addr_r;
    assign Instruction_D = instr_d_r;
    assign PC_D          = pc_d_r;
    assign valid_D       = valid_d_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch.
// A memory model with configurable wait states answers the main instance. A stream
// model derives the expected IF/ID contents from the delivery rules: after reset or a
// redirect, PCs advance by 4 with no gaps, a redirect blanks IF/ID on the next cycle,
// and a stall holds IF/ID. A second instance with RESET_PC = FFFF_FFF8 checks PC wrap.
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall_D = 1'b0;
    logic [31:0] Instruction_D;
    logic [31:0] PC_D;
    logic        valid_D;

    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        valid2;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    int cyc = 0;

    // Memory model controls.
    bit          man_mode = 1'b0;
    bit          hold_en = 1'b0;
    bit          rand_wait = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    int          fixed_wait = 0;
    int          wcnt = 0;
    int          wtarget = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_D(stall_D),
        .Instruction_D(Instruction_D), .PC_D(PC_D), .valid_D(valid_D)
    );

    // Wrap instance: a zero-wait memory that answers combinationally.
    assign ack2   = req2;
    assign rdata2 = word_of(addr2);

    instruction_fetch #(.RESET_PC(WRAP_PC), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .stall_D(1'b0),
        .Instruction_D(instr2), .PC_D(pc2), .valid_D(valid2)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance to the next cycle and drive the memory response for that cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst || man_mode) begin
            imem_ack = 1'b0;
        end else if (imem_req && !(hold_en && imem_addr == hold_addr) && wcnt >= wtarget) begin
            imem_ack = 1'b1;
            wcnt = 0;
            wtarget = rand_wait ? int'($urandom_range(0, 4)) : fixed_wait;
        end else begin
            imem_ack = 1'b0;
            if (imem_req) wcnt++;
        end
        if (rst) wcnt = 0;
        imem_rdata = imem_ack ? word_of(imem_addr) : $urandom;
    endtask

    // Stream model and protocol checks, sampled mid-cycle.
    initial begin
        bit          have_prev;
        logic        p_rst, p_req, p_ack, p_redir, p_stall, p_valid;
        logic [31:0] p_addr, p_instr, p_pc, exp_pc;
        have_prev = 1'b0;
        exp_pc = RESET_PC;
        forever begin
            @(negedge clk);
            if (have_prev) begin
                if (p_rst) begin
                    check("rst_valid", 32'(valid_D), 32'd0);
                    check("rst_instr", Instruction_D, 32'd0);
                    check("rst_pc", PC_D, 32'd0);
                    check("rst_req", 32'(imem_req), 32'd0);
                    check("rst_addr", imem_addr, RESET_PC);
                end else begin
                    if (p_req && !p_ack) begin
                        check("req_held", 32'(imem_req), 32'd1);
                        check("addr_stable", imem_addr, p_addr);
                    end
                    if (p_redir) begin
                        check("redir_valid", 32'(valid_D), 32'd0);
                        check("redir_instr", Instruction_D, 32'd0);
                    end else if (p_stall) begin
                        check("stall_valid", 32'(valid_D), 32'(p_valid));
                        check("stall_instr", Instruction_D, p_instr);
                        check("stall_pc", PC_D, p_pc);
                    end else if (valid_D) begin
                        check("stream_pc", PC_D, exp_pc);
                        check("stream_instr", Instruction_D, word_of(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                        delivered++;
                    end else begin
                        check("idle_instr", Instruction_D, 32'd0);
                    end
                end
            end
            if (rst) exp_pc = RESET_PC;
            else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            p_rst = rst; p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_redir = redirect_valid; p_stall = stall_D;
            p_valid = valid_D; p_instr = Instruction_D; p_pc = PC_D;
            have_prev = 1'b1;
        end
    end

    // Directed phases followed by randomized traffic.
    initial begin
        int          ack_cyc, val_cyc, k;
        bit          ok;
        logic [31:0] wrap_exp [3];
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        // Phase A: zero-wait streaming from reset; latency and wrap.
        step(); step(); step();
        rst = 1'b0;
        ack_cyc = -1; val_cyc = -1; k = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (imem_ack && ack_cyc < 0) ack_cyc = cyc;
            if (valid_D && val_cyc < 0) begin
                val_cyc = cyc;
                check("first_pc", PC_D, 32'h0000_0000);
            end
            if (valid2 && k < 3) begin
                check("wrap_pc", pc2, wrap_exp[k]);
                check("wrap_instr", instr2, word_of(wrap_exp[k]));
                k++;
            end
        end
        check("latency", 32'(val_cyc - ack_cyc), 32'(LAT));
        check("wrap_count", 32'(k), 32'd3);

        // Phase B: three wait states per ack.
        fixed_wait = 3; wtarget = 3;
        for (int i = 0; i < 60; i++) step();

        // Phase C: zero-wait stream, then a 10-cycle stall.
        fixed_wait = 0; wtarget = 0;
        for (int i = 0; i < 10; i++) step();
        stall_D = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("stall_req_stopped", 32'(imem_req), 32'd0);
        stall_D = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Phase D: redirect while the request to 0x20 is outstanding.
        hold_en = 1'b1; hold_addr = 32'h0000_0020;
        rst = 1'b1; step(); step(); rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 32'h0000_0020) begin ok = 1'b1; break; end
            step();
        end
        check("reach_0x20", 32'(ok), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
        step();
        redirect_valid = 1'b0;
        check("redir_next_valid", 32'(valid_D), 32'd0);
        hold_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr != 32'h0000_0020) begin ok = 1'b1; break; end
            step();
        end
        check("redir_req_seen", 32'(ok), 32'd1);
        check("redir_req_addr", imem_addr, 32'h0000_1000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid_D) begin ok = 1'b1; break; end
            step();
        end
        check("redir_valid_seen", 32'(ok), 32'd1);
        check("redir_first_pc", PC_D, 32'h0000_1000);

        // Phase E: redirect, ack and stall all in the same cycle.
        man_mode = 1'b1;
        step();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin ok = 1'b1; break; end
            step();
        end
        check("e_req_seen", 32'(ok), 32'd1);
        imem_ack = 1'b1; imem_rdata = word_of(imem_addr);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; stall_D = 1'b1;
        step();
        redirect_valid = 1'b0; stall_D = 1'b0; man_mode = 1'b0;
        check("e_valid_low", 32'(valid_D), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin ok = 1'b1; break; end
            step();
        end
        check("e_req_seen2", 32'(ok), 32'd1);
        check("e_req_addr", imem_addr, 32'h0000_2000);
        for (int i = 0; i < 10; i++) step();

        // Phase F: reset in the middle of an outstanding request.
        man_mode = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req) begin ok = 1'b1; break; end
        end
        check("f_req_seen", 32'(ok), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; man_mode = 1'b0;
        check("f_req_low", 32'(imem_req), 32'd0);
        check("f_valid_low", 32'(valid_D), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin ok = 1'b1; break; end
            step();
        end
        check("f_restart_seen", 32'(ok), 32'd1);
        check("f_restart_addr", imem_addr, RESET_PC);

        // Phase G: random waits, stalls, redirects and resets.
        delivered = 0;
        rand_wait = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 999) < 2);
            stall_D = ($urandom_range(0, 99) < 20);
            redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_pc = $urandom;
        end
        rst = 1'b0; stall_D = 1'b0; redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("progress", 32'(delivered >= 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
